sram_like_data_responder: RTL and testbench

//  Slave end of the CPU sram-like data port (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata).

---
 rtl/sram_like_data_responder.sv | 134 +++++++++++++
 tb/tb_sram_like_data_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram_like_data_responder.sv
// ----------------------------------------------------------------------------
// sram_like_data_responder
//   Slave end of the CPU sram-like data port. Holds a word-addressed data RAM,
//   accepts at most one request per cycle and returns in-order responses a
//   fixed LATENCY cycles after acceptance, with up to DEPTH requests in flight.
//
// Ports
//   clk      in   1   clock
//   resetn   in   1   synchronous active-low reset
//   req      in   1   request valid
//   wr       in   1   1=store, 0=load
//   size     in   2   0=byte, 1=half, 2=word, 3=reserved
//   addr     in   32  byte address (RAM indexed by addr[ADDR_W+1:2])
//   wdata    in   32  lane-aligned store data
//   hold     in   1   backpressure injection, forces addr_ok low
//   addr_ok  out  1   request accepted when req & addr_ok
//   data_ok  out  1   one-cycle response pulse, in acceptance order
//   rdata    out  32  full RAM word for loads, 0 for stores/misaligned
// ----------------------------------------------------------------------------
module sram_like_data_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = 3;

    logic [31:0]       r_ram  [0:(1<<ADDR_W)-1];
    logic [31:0]       r_snap [0:DEPTH-1];
    logic [AGE_W-1:0]  r_age  [0:DEPTH-1];
    logic [DEPTH-1:0]  r_is_wr;
    logic [DEPTH-1:0]  r_mis;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_be;
    logic              w_mis;
    logic              w_accept;
    logic              w_retire;
    logic              w_unused_addr;

    assign w_idx         = addr[ADDR_W+1:2];
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    always_comb begin
        w_mis = 1'b0;
        w_be  = '0;
        case (size)
            2'd0: w_be = 4'b0001 << addr[1:0];
            2'd1: begin
                w_mis = addr[0];
                w_be  = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                w_mis = (addr[1:0] != 2'b00);
                w_be  = '1;
            end
            default: w_mis = 1'b1;
        endcase
    end

    // Full check uses the registered count only: a retire in the same cycle
    // frees its slot on the following cycle.
    assign addr_ok  = resetn & ~hold & (r_count < CNT_W'(DEPTH));
    assign w_accept = req & addr_ok;
    // Head retires once its age has reached LATENCY-1; data_ok is registered,
    // so the pulse lands LATENCY cycles after the accept edge.
    assign w_retire = (r_count != '0) && (r_age[r_rd_ptr] >= AGE_W'(LATENCY - 1));

    // RAM is not reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (w_accept && wr && !w_mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) r_ram[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Queue payload; loads snapshot the RAM word on the accept edge, which
    // makes every earlier store visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_wr[r_wr_ptr] <= wr;
            r_mis[r_wr_ptr]   <= w_mis;
            r_snap[r_wr_ptr]  <= r_ram[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            data_ok  <= 1'b0;
            rdata    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_age[i] < AGE_W'(LATENCY)) r_age[i] <= r_age[i] + AGE_W'(1);
            end
            // Placed after the age loop so a fresh entry starts at zero.
            if (w_accept) begin
                r_age[r_wr_ptr] <= '0;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            data_ok <= w_retire;
            rdata   <= (w_retire && !r_is_wr[r_rd_ptr] && !r_mis[r_rd_ptr])
                       ? r_snap[r_rd_ptr] : '0;
            if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_data_responder.sv
// ----------------------------------------------------------------------------
// tb_sram_like_data_responder
//   Directed bench for sram_like_data_responder (LATENCY=2, DEPTH=4).
//   Each request carries a hand-computed expected rdata; a response monitor
//   matches data_ok pulses in order and checks latency and rdata.
// ----------------------------------------------------------------------------
module tb_sram_like_data_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    typedef struct {
        int unsigned acc;
        logic [31:0] rd;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc    = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;

    sram_like_data_responder #(
        .ADDR_W (10),
        .LATENCY(LAT),
        .DEPTH  (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .hold   (hold),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_ok) begin
            if (q.size() == 0) begin
                check_val("spurious_data_ok", {31'b0, data_ok}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check_val("latency", cyc - mon_e.acc, LAT);
                check_val("rdata", rdata, mon_e.rd);
            end
        end else if (q.size() != 0 && (cyc - q[0].acc) >= LAT) begin
            check_val("data_ok_missing", {31'b0, data_ok}, 32'd1);
            void'(q.pop_front());
        end
    end

    // Called at posedge+2; leaves at the next posedge+2 with inputs still driven.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_ok, input logic [31:0] exp_rd);
        logic ok;
        exp_t e;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        @(negedge clk);
        ok = addr_ok;
        check_val("addr_ok", {31'b0, ok}, {31'b0, exp_ok});
        @(posedge clk); #2;
        if (ok) begin
            e.acc = cyc;
            e.rd  = exp_rd;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0;
        addr = '0; wdata = '0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
        check_val("rst_data_ok", {31'b0, data_ok}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        resetn = 1'b1;
        idle(1);

        // Word store then load of the same word.
        issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        idle(4);

        // Byte and half-word lane merges into a zeroed word.
        issue(1'b1, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'd0, 32'h1, 32'h0000AA00, 1'b1, 32'h0);
        issue(1'b1, 2'd1, 32'h2, 32'h12340000, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h1234AA00);
        idle(4);

        // Eight back-to-back loads; upper address bits are ignored.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h1234AA00);
            else            issue(1'b0, 2'd2, 32'h1000_0010, 32'h0, 1'b1, 32'hDEADBEEF);
        end
        idle(4);

        // Backpressure: nothing accepted while hold is high.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 32'h0);
        hold = 1'b0;
        issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        issue(1'b0, 2'd0, 32'h3, 32'h0, 1'b1, 32'h1234AA00);
        idle(4);

        // Misaligned and reserved requests write nothing and return zero.
        issue(1'b1, 2'd2, 32'h4, 32'h11111111, 1'b1, 32'h0);
        issue(1'b1, 2'd2, 32'h6, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 32'h4, 32'h0, 1'b1, 32'h11111111);
        issue(1'b1, 2'd3, 32'h4, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'd1, 32'h5, 32'h00FFFF00, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 32'h4, 32'h0, 1'b1, 32'h11111111);
        issue(1'b0, 2'd1, 32'h1, 32'h0, 1'b1, 32'h0);
        idle(4);

        // Reset with three loads in flight: only the first one had retired.
        issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h4, 32'h0, 1'b1, 32'h11111111);
        issue(1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h1234AA00);
        resetn = 1'b0;
        req    = 1'b0;
        @(negedge clk);
        check_val("rst_mid_addr_ok", {31'b0, addr_ok}, 32'd0);
        @(posedge clk); #2;
        q.delete();
        repeat (3) begin
            check_val("rst_mid_data_ok", {31'b0, data_ok}, 32'd0);
            @(posedge clk); #2;
        end
        resetn = 1'b1;
        issue(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        idle(1);

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        check_val("drain", q.size(), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
